view_sel_ctrl: RTL and testbench
================================

Name: view_sel_ctrl

Overview:
- Sequences the 3-bit view selector for the 4-digit hex display: PC low/high, register low/high, instruction low/high.
- Debounces two raw board push-buttons (step, mode).
- Supports manual stepping and timed auto-rotation through the views.
- Sits between the board buttons and the display selector input; the core clock is the only clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (>=2).
- DWELL_CYCLES, 50000000, cycles each view is held in auto mode (>=2).
- NUM_VIEWS, 6, number of valid selector codes, 0..NUM_VIEWS-1 (2..8).
- BLANK_CYCLES, 4, blanking length after a view change; used only with the optional feature (>=1).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk.
- btn_step  in  1  raw step button, active-high, asynchronous to clk.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- sel  out  3  view selector to the display.
- auto_mode  out  1  1 = AUTO state, 0 = MANUAL state.
- sel_changed  out  1  one-cycle pulse in the same cycle the new sel value first appears.
- blank  out  1  display blank request; present only with VIEW_BLANK_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): sel=0, auto_mode=0, sel_changed=0, blank=0. Synchronizers, debounce counters, debounced levels, edge detectors and the dwell counter all clear to 0. State is MANUAL.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debounce, per button:
  - A counter increments while the synchronized level differs from the debounced level.
  - The counter clears whenever the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Press pulse: a one-cycle pulse on a 0->1 transition of the debounced level. Release generates nothing.
- Latency: a raw edge held stable produces its press pulse 2+DEBOUNCE_CYCLES cycles later. sel updates on the next edge after the pulse.
- Advance: sel <= (sel==NUM_VIEWS-1) ? 0 : sel+1. sel never leaves 0..NUM_VIEWS-1.
- FSM, two states:
  - MANUAL: step press advances sel. Mode press goes to AUTO and clears the dwell counter.
  - AUTO: the dwell counter increments every cycle. At DWELL_CYCLES-1 it advances sel and clears. A step press advances sel immediately and clears the dwell counter. A mode press goes to MANUAL, and sel holds its current value.
- Priority: if mode and step press occur in the same cycle, the mode toggle is taken and the step press is dropped (no advance). In AUTO, if a dwell expiry coincides with a step press, sel advances exactly once.
- sel_changed: asserts exactly once per advance, in the cycle the new sel value is visible. It never asserts on a mode change alone.
- Buttons held continuously produce no repeat presses.
- Reset mid-operation: all state returns to the reset values immediately. A button still held at reset release is accepted as a fresh press once debounced.

Optional Feature:
- Macro: VIEW_BLANK_EN.
- Defined:
  - The blank output exists.
  - blank asserts in the same cycle as sel_changed and stays high for exactly BLANK_CYCLES cycles.
  - A new advance during blanking restarts the count.
  - Blanking does not delay sel.
- Undefined: the blank port and its counter are absent. All other behaviour is identical.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, DWELL_CYCLES=10, NUM_VIEWS=6, BLANK_CYCLES=3.
- Reset: hold rst_n=0 with buttons toggling -> sel=0, auto_mode=0, sel_changed=0 throughout. After release, no pulse without a press.
- Debounce: btn_step glitches high for 3 cycles -> sel stays 0. btn_step held high 20 cycles -> sel=1 exactly 2+4+1 cycles after the rising edge, with a single sel_changed pulse.
- Wrap: 7 clean step presses in MANUAL -> sel sequence 1,2,3,4,5,0,1.
- Auto: mode press -> auto_mode=1, then sel advances every 10 cycles (0->1->2). A step press at dwell count 5 -> sel advances that cycle and the next auto advance comes 10 cycles later. A second mode press -> auto_mode=0 and sel frozen for 50 cycles.
- Simultaneous: step and mode raw edges in the same cycle while MANUAL -> auto_mode=1, sel unchanged, no sel_changed.
- With VIEW_BLANK_EN: step press -> blank high 3 cycles starting with sel_changed. Two advances 2 cycles apart -> blank high for 5 contiguous cycles. Assert rst_n=0 mid-rotation -> sel=0 and blank=0 immediately.

Source files
------------

// File: rtl/view_sel_ctrl.sv
// view_sel_ctrl: debounced step/mode buttons drive manual or timed rotation of the display view selector.
// Define VIEW_BLANK_EN to add the blank output that masks the display for BLANK_CYCLES after each view change.
module view_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DWELL_CYCLES    = 50000000,
    parameter int NUM_VIEWS       = 6,
    parameter int BLANK_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step,
    input  logic       btn_mode,
    output logic [2:0] sel,
    output logic       auto_mode,
    output logic       sel_changed
`ifdef VIEW_BLANK_EN
    ,
    output logic       blank
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DW_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [2:0] LAST = 3'(NUM_VIEWS - 1);

    if (DEBOUNCE_CYCLES < 2 || DWELL_CYCLES < 2 || NUM_VIEWS < 2 || NUM_VIEWS > 8 || BLANK_CYCLES < 1) begin : g_bad_param
        $error("view_sel_ctrl: parameter out of range");
    end

    typedef enum logic {MANUAL, AUTO} state_t;

    // bit 0 = step, bit 1 = mode
    logic [1:0] btn, s1, s2, deb, deb_d, press;
    logic [CW-1:0] cnt [2];
    state_t state, state_nxt;
    logic [DW-1:0] dwell, dwell_nxt;
    logic adv;

    assign btn   = {btn_mode, btn_step};
    assign press = deb & ~deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            deb    <= '0;
            deb_d  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == DB_MAX) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // a mode press wins over a same-cycle step press or dwell expiry
    always_comb begin
        state_nxt = state;
        dwell_nxt = '0;
        adv       = 1'b0;
        if (press[1]) state_nxt = (state == MANUAL) ? AUTO : MANUAL;
        else if (state == AUTO) begin
            adv       = press[0] || dwell == DW_MAX;
            dwell_nxt = adv ? '0 : dwell + 1'b1;
        end else adv = press[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MANUAL;
            dwell       <= '0;
            sel         <= '0;
            sel_changed <= 1'b0;
        end else begin
            state       <= state_nxt;
            dwell       <= dwell_nxt;
            sel         <= adv ? ((sel == LAST) ? 3'd0 : sel + 3'd1) : sel;
            sel_changed <= adv;
        end
    end

    assign auto_mode = state == AUTO;

`ifdef VIEW_BLANK_EN
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYCLES);
    logic [BW-1:0] bcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= '0;
        else bcnt <= adv ? BLANK_MAX : (bcnt != '0) ? bcnt - 1'b1 : bcnt;
    end

    assign blank = bcnt != '0;
`endif
endmodule

// File: tb/tb_view_sel_ctrl.sv
// tb_view_sel_ctrl: directed checks of debounce, wrap, auto rotation, priority and blanking.
module tb_view_sel_ctrl;
    logic clk, rst_n, btn_step, btn_mode;
    logic [2:0] sel;
    logic auto_mode, sel_changed;
`ifdef VIEW_BLANK_EN
    logic blank;
`endif
    int checks = 0;
    int failures = 0;

    view_sel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES(10),
        .NUM_VIEWS(6),
        .BLANK_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_step(btn_step),
        .btn_mode(btn_mode),
        .sel(sel),
        .auto_mode(auto_mode),
        .sel_changed(sel_changed)
`ifdef VIEW_BLANK_EN
        ,
        .blank(blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        btn_step = 1'b0;
        btn_mode = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_step = i[0];
            btn_mode = i[1];
            tick();
            checks++;
            if (sel !== 3'd0 || auto_mode !== 1'b0 || sel_changed !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d sel=%0d auto=%0b chg=%0b expected 0/0/0", i, sel, auto_mode, sel_changed);
            end
        end
        btn_step = 1'b0;
        btn_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(sel_changed);
        end
        checks++;
        if (n !== 0 || sel !== 3'd0 || auto_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle pulses=%0d sel=%0d auto=%0b expected 0/0/0", n, sel, auto_mode);
        end
    endtask

    task automatic test_debounce();
        int n;
        btn_step = 1'b1;
        repeat (3) tick();
        btn_step = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n += int'(sel_changed);
        end
        checks++;
        if (n !== 0 || sel !== 3'd0) begin
            failures++;
            $display("FAIL glitch pulses=%0d sel=%0d expected 0/0", n, sel);
        end
        btn_step = 1'b1;
        repeat (6) tick();
        checks++;
        if (sel !== 3'd0 || sel_changed !== 1'b0) begin
            failures++;
            $display("FAIL press_early sel=%0d chg=%0b expected 0/0", sel, sel_changed);
        end
        tick();
        checks++;
        if (sel !== 3'd1 || sel_changed !== 1'b1) begin
            failures++;
            $display("FAIL press_latency sel=%0d chg=%0b expected 1/1", sel, sel_changed);
        end
        n = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) btn_step = 1'b0;
            tick();
            n += int'(sel_changed);
        end
        checks++;
        if (n !== 0 || sel !== 3'd1) begin
            failures++;
            $display("FAIL hold_no_repeat pulses=%0d sel=%0d expected 0/1", n, sel);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_seq [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            btn_step = 1'b1;
            repeat (7) tick();
            checks++;
            if (sel !== exp_seq[i] || sel_changed !== 1'b1) begin
                failures++;
                $display("FAIL wrap step=%0d sel=%0d chg=%0b expected %0d/1", i, sel, sel_changed, exp_seq[i]);
            end
            btn_step = 1'b0;
            repeat (10) tick();
        end
    endtask

    task automatic test_auto();
        int n;
        apply_reset();
        btn_mode = 1'b1;
        repeat (7) tick();
        checks++;
        if (auto_mode !== 1'b1 || sel !== 3'd0) begin
            failures++;
            $display("FAIL auto_enter auto=%0b sel=%0d expected 1/0", auto_mode, sel);
        end
        btn_mode = 1'b0;
        repeat (9) tick();
        checks++;
        if (sel !== 3'd0) begin
            failures++;
            $display("FAIL auto_dwell0 sel=%0d expected 0", sel);
        end
        tick();
        checks++;
        if (sel !== 3'd1 || sel_changed !== 1'b1) begin
            failures++;
            $display("FAIL auto_adv1 sel=%0d chg=%0b expected 1/1", sel, sel_changed);
        end
        repeat (9) tick();
        checks++;
        if (sel !== 3'd1) begin
            failures++;
            $display("FAIL auto_dwell1 sel=%0d expected 1", sel);
        end
        btn_step = 1'b1;
        tick();
        checks++;
        if (sel !== 3'd2 || sel_changed !== 1'b1) begin
            failures++;
            $display("FAIL auto_adv2 sel=%0d chg=%0b expected 2/1", sel, sel_changed);
        end
        repeat (5) tick();
        checks++;
        if (sel !== 3'd2) begin
            failures++;
            $display("FAIL auto_before_step sel=%0d expected 2", sel);
        end
        tick();
        checks++;
        if (sel !== 3'd3 || sel_changed !== 1'b1) begin
            failures++;
            $display("FAIL auto_step sel=%0d chg=%0b expected 3/1", sel, sel_changed);
        end
        btn_step = 1'b0;
        repeat (9) tick();
        checks++;
        if (sel !== 3'd3) begin
            failures++;
            $display("FAIL auto_restart_dwell sel=%0d expected 3", sel);
        end
        tick();
        checks++;
        if (sel !== 3'd4 || sel_changed !== 1'b1) begin
            failures++;
            $display("FAIL auto_after_step sel=%0d chg=%0b expected 4/1", sel, sel_changed);
        end
        btn_mode = 1'b1;
        repeat (7) tick();
        checks++;
        if (auto_mode !== 1'b0 || sel !== 3'd4) begin
            failures++;
            $display("FAIL auto_exit auto=%0b sel=%0d expected 0/4", auto_mode, sel);
        end
        btn_mode = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n += int'(sel_changed);
        end
        checks++;
        if (n !== 0 || sel !== 3'd4 || auto_mode !== 1'b0) begin
            failures++;
            $display("FAIL manual_frozen pulses=%0d sel=%0d auto=%0b expected 0/4/0", n, sel, auto_mode);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        btn_step = 1'b1;
        btn_mode = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n += int'(sel_changed);
        end
        checks++;
        if (auto_mode !== 1'b1 || sel !== 3'd4 || n !== 0) begin
            failures++;
            $display("FAIL simultaneous auto=%0b sel=%0d pulses=%0d expected 1/4/0", auto_mode, sel, n);
        end
        btn_step = 1'b0;
        btn_mode = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_sel [6] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
        logic exp_chg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_blank [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        btn_mode = 1'b1;
        repeat (7) tick();
        btn_mode = 1'b0;
        repeat (5) tick();
        btn_step = 1'b1;
        repeat (4) tick();
        checks++;
        if (sel !== 3'd0 || auto_mode !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start sel=%0d auto=%0b expected 0/1", sel, auto_mode);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (sel !== exp_sel[i] || sel_changed !== exp_chg[i]) begin
                failures++;
                $display("FAIL b2b cyc=%0d sel=%0d chg=%0b expected %0d/%0b", i, sel, sel_changed, exp_sel[i], exp_chg[i]);
            end
`ifdef VIEW_BLANK_EN
            checks++;
            if (blank !== exp_blank[i]) begin
                failures++;
                $display("FAIL blank cyc=%0d blank=%0b expected %0b", i, blank, exp_blank[i]);
            end
`else
            if (exp_blank[i] === 1'bx) $display("unexpected blank table");
`endif
        end
        btn_step = 1'b0;
        repeat (7) tick();
        checks++;
        if (sel !== 3'd3 || sel_changed !== 1'b1) begin
            failures++;
            $display("FAIL b2b_next sel=%0d chg=%0b expected 3/1", sel, sel_changed);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 3'd0 || auto_mode !== 1'b0 || sel_changed !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid sel=%0d auto=%0b chg=%0b expected 0/0/0", sel, auto_mode, sel_changed);
        end
`ifdef VIEW_BLANK_EN
        checks++;
        if (blank !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_blank blank=%0b expected 0", blank);
        end
`endif
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        btn_step = 1'b0;
        btn_mode = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_debounce();
        test_wrap();
        test_auto();
        test_simultaneous();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
